usb_cmd_sequencer: RTL and testbench

Command sequencer between the USB FT232H bridge and the scanner configuration register bus. Pulls fixed 5-byte command frames from the bridge RX FIFO read port, checks them, executes register writes/reads, and returns a 5-byte reply frame through the bridge's Avalon-MM slave, polling TX status so no byte is ever dropped. Single clock domain (system clock); the bridge RX FIFO read clock is driven from the same clock.

---
 rtl/usb_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_usb_cmd_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cmd_sequencer.sv
// Command sequencer: fetches 5-byte frames from the FT232H bridge RX FIFO, executes config
// register writes/reads and returns a 5-byte reply through the bridge slave, polling TX status.
module usb_cmd_sequencer #(
    parameter int unsigned READ_LATENCY   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    output logic       rx_rdreq_o,
    input  logic [7:0] rx_rddata_i,
    input  logic [8:0] rx_rdusedw_i,
    output logic [3:0] av_address_o,
    output logic       av_read_o,
    input  logic [7:0] av_readdata_i,
    output logic       av_write_o,
    output logic [7:0] av_writedata_o,
    output logic [7:0] cfg_addr_o,
    output logic       cfg_wr_o,
    output logic [7:0] cfg_wdata_o,
    output logic       cfg_rd_o,
    input  logic [7:0] cfg_rdata_i,
    output logic       busy_o,
    output logic [7:0] err_count_o
);

    localparam int unsigned LatW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LatW-1:0] LatLast = LatW'(READ_LATENCY);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StHunt, StOpc, StAdr, StDat, StChk, StExec, StRdReg, StPoll, StPush
    } state_e;

    typedef enum logic [1:0] {FIdle, FReq, FCap, FGap} fetch_e;

    state_e          state_q, state_d;
    fetch_e          fph_q, fph_d;
    logic [7:0]      opc_q, opc_d, adr_q, adr_d, dat_q, dat_d;
    logic [7:0]      status_q, status_d, rep_data_q, rep_data_d;
    logic [2:0]      idx_q, idx_d;
    logic [LatW-1:0] lat_q, lat_d;
    logic [ToW-1:0]  to_q, to_d;
    logic [7:0]      err_q, err_d;
    logic            rdreq_q, rdreq_d, av_read_q, av_read_d, av_write_q, av_write_d;
    logic [3:0]      av_addr_q, av_addr_d;
    logic [7:0]      av_wdata_q, av_wdata_d;
    logic [7:0]      cfg_addr_q, cfg_addr_d, cfg_wdata_q, cfg_wdata_d;
    logic            cfg_wr_q, cfg_wr_d, cfg_rd_q, cfg_rd_d;
    logic            busy_q, busy_d;

    logic       capture, fetch_st, frame_st, err_inc, start_poll;
    logic [7:0] reply_byte;

    always_comb begin
        reply_byte = status_q ^ adr_q ^ rep_data_q;
        case (idx_q)
            3'd0:    reply_byte = 8'hAA;
            3'd1:    reply_byte = status_q;
            3'd2:    reply_byte = adr_q;
            3'd3:    reply_byte = rep_data_q;
            default: reply_byte = status_q ^ adr_q ^ rep_data_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        fph_d       = fph_q;
        opc_d       = opc_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        status_d    = status_q;
        rep_data_d  = rep_data_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        to_d        = to_q;
        err_d       = err_q;
        rdreq_d     = 1'b0;
        av_read_d   = 1'b0;
        av_write_d  = 1'b0;
        av_addr_d   = av_addr_q;
        av_wdata_d  = av_wdata_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        cfg_wr_d    = 1'b0;
        cfg_rd_d    = 1'b0;
        err_inc     = 1'b0;
        start_poll  = 1'b0;

        capture  = (fph_q == FCap);
        frame_st = (state_q == StOpc) || (state_q == StAdr) ||
                   (state_q == StDat) || (state_q == StChk);
        fetch_st = frame_st || (state_q == StHunt);

        // Request, capture, gap: at most one byte every three cycles.
        case (fph_q)
            FReq:    fph_d = FCap;
            FCap:    fph_d = FGap;
            default: begin
                if (fetch_st && (rx_rdusedw_i != 9'd0)) begin
                    rdreq_d = 1'b1;
                    fph_d   = FReq;
                end else begin
                    fph_d = FIdle;
                end
            end
        endcase

        case (state_q)
            StHunt: if (capture && (rx_rddata_i == 8'h55)) state_d = StOpc;
            StOpc: if (capture) begin
                opc_d   = rx_rddata_i;
                state_d = StAdr;
            end
            StAdr: if (capture) begin
                adr_d   = rx_rddata_i;
                state_d = StDat;
            end
            StDat: if (capture) begin
                dat_d   = rx_rddata_i;
                state_d = StChk;
            end
            StChk: if (capture) begin
                rep_data_d = dat_q;
                state_d    = StExec;
                if ((opc_q ^ adr_q ^ dat_q) != rx_rddata_i) begin
                    status_d = 8'h01;
                    err_inc  = 1'b1;
                end else if (opc_q == 8'h01) begin
                    status_d    = 8'h00;
                    cfg_wr_d    = 1'b1;
                    cfg_addr_d  = adr_q;
                    cfg_wdata_d = dat_q;
                end else if (opc_q == 8'h02) begin
                    status_d   = 8'h00;
                    cfg_rd_d   = 1'b1;
                    cfg_addr_d = adr_q;
                end else begin
                    status_d = 8'h02;
                    err_inc  = 1'b1;
                end
            end
            StExec: begin
                idx_d = 3'd0;
                if (cfg_rd_q) state_d = StRdReg;
                else          start_poll = 1'b1;
            end
            StRdReg: begin
                rep_data_d = cfg_rdata_i;
                start_poll = 1'b1;
            end
            StPoll: begin
                if (lat_q == LatLast) begin
                    if (av_readdata_i[7]) begin
                        av_write_d = 1'b1;
                        av_addr_d  = 4'd0;
                        av_wdata_d = reply_byte;
                        state_d    = StPush;
                    end else begin
                        start_poll = 1'b1;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            StPush: begin
                if (idx_q == 3'd4) begin
                    idx_d   = 3'd0;
                    state_d = StHunt;
                end else begin
                    idx_d      = idx_q + 3'd1;
                    start_poll = 1'b1;
                end
            end
            default: state_d = StHunt;
        endcase

        if (start_poll) begin
            av_read_d = 1'b1;
            av_addr_d = 4'd3;
            lat_d     = '0;
            state_d   = StPoll;
        end

        // Inter-byte idle watchdog; a captured byte never coincides with an abort.
        if (!frame_st || capture) begin
            to_d = '0;
        end else if (to_q == ToLast) begin
            to_d    = '0;
            err_inc = 1'b1;
            state_d = StHunt;
        end else begin
            to_d = to_q + 1'b1;
        end

        if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        busy_d = (state_d != StHunt);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= StHunt;
            fph_q       <= FIdle;
            opc_q       <= 8'h00;
            adr_q       <= 8'h00;
            dat_q       <= 8'h00;
            status_q    <= 8'h00;
            rep_data_q  <= 8'h00;
            idx_q       <= 3'd0;
            lat_q       <= '0;
            to_q        <= '0;
            err_q       <= 8'h00;
            rdreq_q     <= 1'b0;
            av_read_q   <= 1'b0;
            av_write_q  <= 1'b0;
            av_addr_q   <= 4'd0;
            av_wdata_q  <= 8'h00;
            cfg_addr_q  <= 8'h00;
            cfg_wdata_q <= 8'h00;
            cfg_wr_q    <= 1'b0;
            cfg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fph_q       <= fph_d;
            opc_q       <= opc_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            status_q    <= status_d;
            rep_data_q  <= rep_data_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            to_q        <= to_d;
            err_q       <= err_d;
            rdreq_q     <= rdreq_d;
            av_read_q   <= av_read_d;
            av_write_q  <= av_write_d;
            av_addr_q   <= av_addr_d;
            av_wdata_q  <= av_wdata_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            cfg_wr_q    <= cfg_wr_d;
            cfg_rd_q    <= cfg_rd_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_rdreq_o     = rdreq_q;
    assign av_address_o   = av_addr_q;
    assign av_read_o      = av_read_q;
    assign av_write_o     = av_write_q;
    assign av_writedata_o = av_wdata_q;
    assign cfg_addr_o     = cfg_addr_q;
    assign cfg_wr_o       = cfg_wr_q;
    assign cfg_wdata_o    = cfg_wdata_q;
    assign cfg_rd_o       = cfg_rd_q;
    assign busy_o         = busy_q;
    assign err_count_o    = err_q;

endmodule

// File: tb/tb_usb_cmd_sequencer.sv
// Bench for usb_cmd_sequencer: RX FIFO, bridge slave and config bus models with a reply
// scoreboard fed from a frame-level reference model.
module tb_usb_cmd_sequencer;

    localparam int unsigned RL = 3;
    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_rdreq, av_read, av_write, cfg_wr, cfg_rd, busy;
    logic [7:0] rx_rddata = 8'h00;
    logic [8:0] rx_rdusedw;
    logic [3:0] av_address;
    logic [7:0] av_readdata, av_writedata, cfg_addr, cfg_wdata, cfg_rdata, err_count;

    always #5 clk = ~clk;

    usb_cmd_sequencer #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .rx_rdreq_o(rx_rdreq), .rx_rddata_i(rx_rddata), .rx_rdusedw_i(rx_rdusedw),
        .av_address_o(av_address), .av_read_o(av_read), .av_readdata_i(av_readdata),
        .av_write_o(av_write), .av_writedata_o(av_writedata),
        .cfg_addr_o(cfg_addr), .cfg_wr_o(cfg_wr), .cfg_wdata_o(cfg_wdata),
        .cfg_rd_o(cfg_rd), .cfg_rdata_i(cfg_rdata),
        .busy_o(busy), .err_count_o(err_count)
    );

    logic [7:0] rx_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int vectors = 0, miscompares = 0, viol = 0;
    int wr_count = 0, rd_count = 0, wr_seen = 0, poll_count = 0, stall_used = 0;
    int stall_after = -1, stall_polls = 0;
    logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, rd_addr = 8'h00, rd_value = 8'h00;
    logic [7:0] r0 = 8'h00, r1 = 8'h00, r2 = 8'h00;
    logic [2:0] rpend = 3'b000;
    logic       ready_sampled = 1'b0, rd_dly = 1'b0;
    logic       p_rq = 1'b0, p_ar = 1'b0, p_aw = 1'b0, p_cw = 1'b0, p_cr = 1'b0;

    assign rx_rdusedw  = 9'(rx_q.size());
    assign av_readdata = rpend[2] ? r2 : 8'h00;
    assign cfg_rdata   = rd_dly ? rd_value : 8'h00;

    always @(posedge clk) begin
        if (!reset_n) begin
            rpend <= 3'b000; ready_sampled <= 1'b0; rd_dly <= 1'b0;
            p_rq <= 1'b0; p_ar <= 1'b0; p_aw <= 1'b0; p_cw <= 1'b0; p_cr <= 1'b0;
        end else begin
            if (rx_rdreq) begin
                if (rx_q.size() > 0) rx_rddata <= rx_q.pop_front();
                else viol++;
            end
            rpend <= {rpend[1:0], av_read};
            r1 <= r0;
            r2 <= r1;
            if (av_read) begin
                poll_count++;
                if (rpend != 3'b000 || av_address != 4'd3) viol++;
                if (wr_seen == stall_after && stall_used < stall_polls) begin
                    r0 <= 8'h00;
                    stall_used++;
                end else begin
                    r0 <= 8'h80;
                end
            end
            if (rpend[2]) ready_sampled <= r2[7];
            if (av_write) begin
                if (!ready_sampled || av_address != 4'd0) viol++;
                ready_sampled <= 1'b0;
                got_q.push_back(av_writedata);
                wr_seen++;
                stall_used = 0;
            end
            if (av_read && av_write) viol++;
            if ((rx_rdreq && p_rq) || (av_read && p_ar) || (av_write && p_aw) ||
                (cfg_wr && p_cw) || (cfg_rd && p_cr)) viol++;
            p_rq <= rx_rdreq; p_ar <= av_read; p_aw <= av_write; p_cw <= cfg_wr; p_cr <= cfg_rd;
            rd_dly <= cfg_rd;
            if (cfg_wr) begin
                wr_count++;
                wr_addr <= cfg_addr;
                wr_data <= cfg_wdata;
            end
            if (cfg_rd) begin
                rd_count++;
                rd_addr <= cfg_addr;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference reply for a command frame {55, opc, adr, dat, chk}.
    function automatic logic [39:0] reply_for(input logic [39:0] f, input logic [7:0] rdv);
        logic [7:0] opc, adr, dat, st, d;
        opc = f[31:24]; adr = f[23:16]; dat = f[15:8];
        if ((opc ^ adr ^ dat) != f[7:0]) st = 8'h01;
        else if (opc == 8'h01 || opc == 8'h02) st = 8'h00;
        else st = 8'h02;
        d = (st == 8'h00 && opc == 8'h02) ? rdv : dat;
        return {8'hAA, st, adr, d, st ^ adr ^ d};
    endfunction

    task automatic send(input logic [39:0] f, input logic expect_reply);
        logic [39:0] r;
        r = reply_for(f, rd_value);
        for (int i = 4; i >= 0; i--) begin
            rx_q.push_back(f[i*8 +: 8]);
            if (expect_reply) exp_q.push_back(r[i*8 +: 8]);
        end
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int cyc = 0;
        while (got_q.size() < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_bytes"}, got_q.size(), n);
    endtask

    task automatic cmp_reply(input string tag);
        for (int i = 0; i < 5; i++)
            if (got_q.size() > 0 && exp_q.size() > 0) chk(tag, got_q.pop_front(), exp_q.pop_front());
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_strobes"}, {rx_rdreq, av_read, av_write, cfg_wr, cfg_rd, busy}, 0);
        chk({tag, "_av"}, {av_address, av_writedata}, 0);
        chk({tag, "_cfg"}, {cfg_addr, cfg_wdata}, 0);
        chk({tag, "_err"}, err_count, 0);
    endtask

    initial begin
        int p0, w0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Register write
        p0 = poll_count; w0 = wr_count;
        send(40'h55_01_10_3C_2D, 1'b1);
        wait_bytes(5, "wr");
        cmp_reply("wr_reply");
        chk("wr_count", wr_count - w0, 1);
        chk("wr_addr_data", {wr_addr, wr_data}, 16'h103C);
        chk("wr_polls", poll_count - p0, 5);
        chk("wr_err", err_count, 0);
        chk("wr_cfg_hold", {cfg_addr, cfg_wdata}, 16'h103C);

        // Register read
        rd_value = 8'h9E; w0 = wr_count;
        send(40'h55_02_21_00_23, 1'b1);
        wait_bytes(5, "rd");
        cmp_reply("rd_reply");
        chk("rd_count", rd_count, 1);
        chk("rd_addr", rd_addr, 8'h21);
        chk("rd_no_wr", wr_count - w0, 0);

        // Bad checksum, then bad opcode
        send(40'h55_01_10_3C_00, 1'b1);
        wait_bytes(5, "badchk");
        cmp_reply("badchk_reply");
        chk("badchk_err", err_count, 1);
        chk("badchk_no_strobe", (wr_count - w0) + (rd_count - 1), 0);
        send(40'h55_07_00_00_07, 1'b1);
        wait_bytes(5, "badop");
        cmp_reply("badop_reply");
        chk("badop_err", err_count, 2);

        // Leading garbage, then 0x55 used as field data
        rx_q.push_back(8'h00);
        rx_q.push_back(8'hFF);
        send(40'h55_01_02_03_00, 1'b1);
        wait_bytes(5, "resync");
        cmp_reply("resync_reply");
        chk("resync_wr", {wr_addr, wr_data}, 16'h0203);
        send(40'h55_01_55_01_55, 1'b1);
        wait_bytes(5, "data55");
        cmp_reply("data55_reply");
        chk("data55_wr", {wr_addr, wr_data}, 16'h5501);

        // TX backpressure: 50 not-ready polls before the third reply byte
        p0 = poll_count;
        stall_after = wr_seen + 2; stall_polls = 50;
        send(40'h55_01_44_12_57, 1'b1);
        wait_bytes(5, "bp");
        cmp_reply("bp_reply");
        chk("bp_polls", poll_count - p0, 55);
        stall_after = -1;
        repeat (30) @(negedge clk);
        chk("bp_no_dup", got_q.size(), 0);

        // Inter-byte timeout
        rx_q.push_back(8'h55);
        rx_q.push_back(8'h01);
        for (int c = 0; c < 100 && rx_q.size() != 0; c++) @(negedge clk);
        chk("to_fifo_drained", rx_q.size(), 0);
        repeat (98) @(negedge clk);
        chk("to_still_busy", {busy, err_count}, {1'b1, 8'd2});
        repeat (6) @(negedge clk);
        chk("to_abort", {busy, err_count}, {1'b0, 8'd3});
        repeat (20) @(negedge clk);
        chk("to_no_reply", got_q.size(), 0);

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            send(40'h55_01_10_3C_00, 1'b0);
            wait_bytes(5, "sat");
            got_q.delete();
            if (i == 250) chk("sat_254", err_count, 254);
        end
        chk("sat_255", err_count, 255);

        // Reset in the middle of a reply
        stall_after = wr_seen + 2; stall_polls = 1000;
        send(40'h55_01_66_77_10, 1'b0);
        wait_bytes(2, "mid");
        repeat (10) @(negedge clk);
        chk("mid_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1 check_reset("mid_reset");
        stall_after = -1;
        repeat (3) @(negedge clk);
        rx_q.delete(); got_q.delete(); exp_q.delete();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        w0 = wr_count;
        send(40'h55_01_33_44_76, 1'b1);
        wait_bytes(5, "post");
        cmp_reply("post_reply");
        chk("post_wr", {wr_addr, wr_data, 8'(wr_count - w0)}, 24'h334401);
        chk("protocol_violations", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
